fwd_ctrl: RTL and testbench

- Tracks destination registers through the EX/MEM/WB stages of the 5-stage MIPS pipeline.
- Produces the 2-bit select codes that steer the EX-stage operand mux4 instances (A and B operands); it sits at the select end of those muxes.
- Detects load-use hazards and drives a one-cycle stall/bubble.
- Holds the register-write tag for writeback.

---
 rtl/fwd_ctrl.sv | 107 ++++++++++
 tb/tb_fwd_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard control for the 5-stage MIPS pipeline.
// Tracks EX/MEM/WB destination tags; drives operand-mux selects, stall, and the writeback tag.
module fwd_ctrl #(
   parameter int unsigned REG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_dst,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             flush_ex,
   output logic             stall_id,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             wb_regwrite,
   output logic [REG_W-1:0] wb_dst
);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] dst;
      logic             regwrite;
      logic             memread;
   } ex_slot_t;

   // Downstream slots keep only the fields that are ever read; rs/rt die after EX.
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dst;
      logic             regwrite;
      logic             memread;
   } mem_slot_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dst;
      logic             regwrite;
   } wb_slot_t;

   ex_slot_t  r_ex;
   mem_slot_t r_mem;
   wb_slot_t  r_wb;
   logic      w_haz;
   logic      w_ex_load;

   assign w_ex_load = r_ex.valid & r_ex.memread & r_ex.regwrite & (r_ex.dst != '0);
   assign w_haz     = id_valid & w_ex_load & ((r_ex.dst == id_rs) | (r_ex.dst == id_rt));
   assign stall_id  = w_haz & ~flush_ex;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_mem.valid    <= r_ex.valid;
         r_mem.dst      <= r_ex.dst;
         r_mem.regwrite <= r_ex.regwrite;
         r_mem.memread  <= r_ex.memread;
         r_wb.valid     <= r_mem.valid;
         r_wb.dst       <= r_mem.dst;
         r_wb.regwrite  <= r_mem.regwrite;
         if (id_valid & ~stall_id & ~flush_ex) begin
            r_ex.valid    <= 1'b1;
            r_ex.rs       <= id_rs;
            r_ex.rt       <= id_rt;
            r_ex.dst      <= id_dst;
            r_ex.regwrite <= id_regwrite;
            r_ex.memread  <= id_memread;
         end else begin
            r_ex <= '0;
         end
      end
   end

   function automatic logic [1:0] fwd_sel(
      input logic [REG_W-1:0] src,
      input mem_slot_t        mem,
      input wb_slot_t         wb
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (mem.valid & mem.regwrite & ~mem.memread & (mem.dst != '0) & (mem.dst == src))
         sel = 2'b01;
      else if (wb.valid & wb.regwrite & (wb.dst != '0) & (wb.dst == src))
         sel = 2'b10;
      return sel;
   endfunction

   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (r_ex.valid) begin
         fwd_a_sel = fwd_sel(r_ex.rs, r_mem, r_wb);
         fwd_b_sel = fwd_sel(r_ex.rt, r_mem, r_wb);
      end
   end

   assign wb_regwrite = r_wb.valid & r_wb.regwrite & (r_wb.dst != '0);
   assign wb_dst      = r_wb.dst;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: reset, MEM/WB forwarding, load-use stall, $0, flush, writeback tag.
module tb_fwd_ctrl;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_dst;
   logic       id_regwrite;
   logic       id_memread;
   logic       flush_ex;
   logic       stall_id;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;
   logic       wb_regwrite;
   logic [4:0] wb_dst;

   int n_pass;
   int n_total;

   fwd_ctrl #(.REG_W(5)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .flush_ex(flush_ex),
      .stall_id(stall_id), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .wb_regwrite(wb_regwrite), .wb_dst(wb_dst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst, input logic rw, input logic mr);
      id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
      id_regwrite = rw; id_memread = mr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      set_id(0, 0, 0, 0, 0, 0);
      flush_ex = 0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      #1;
      n_total++; if ({stall_id, fwd_a_sel, fwd_b_sel, wb_regwrite, wb_dst} !== 11'd0)
         $display("FAIL reset_outputs: got %b want 0", {stall_id, fwd_a_sel, fwd_b_sel, wb_regwrite, wb_dst});
      else n_pass++;
      tick();
      rst = 0;
   endtask

   task automatic test_mem_fwd();
      drain();
      set_id(1, 1, 2, 3, 1, 0);   // add $3
      tick();
      set_id(1, 3, 9, 10, 1, 0);  // sub rs=$3
      n_total++; if (stall_id !== 1'b0) $display("FAIL mem_fwd_nostall_id: got %b want 0", stall_id); else n_pass++;
      tick();
      set_id(0, 0, 0, 0, 0, 0);
      n_total++; if (fwd_a_sel !== 2'b01) $display("FAIL mem_fwd_a: got %b want 01", fwd_a_sel); else n_pass++;
      n_total++; if (fwd_b_sel !== 2'b00) $display("FAIL mem_fwd_b: got %b want 00", fwd_b_sel); else n_pass++;
      n_total++; if (stall_id !== 1'b0) $display("FAIL mem_fwd_stall: got %b want 0", stall_id); else n_pass++;
   endtask

   task automatic test_wb_fwd();
      drain();
      set_id(1, 1, 2, 4, 1, 0);   // add $4
      tick();
      set_id(0, 0, 0, 0, 0, 0);   // nop
      tick();
      set_id(1, 9, 4, 11, 1, 0);  // or rt=$4
      tick();
      set_id(0, 0, 0, 0, 0, 0);
      n_total++; if (fwd_b_sel !== 2'b10) $display("FAIL wb_fwd_b: got %b want 10", fwd_b_sel); else n_pass++;
      n_total++; if (fwd_a_sel !== 2'b00) $display("FAIL wb_fwd_a: got %b want 00", fwd_a_sel); else n_pass++;
   endtask

   task automatic test_priority();
      drain();
      set_id(1, 1, 2, 4, 1, 0);   // add $4
      tick();
      set_id(1, 2, 3, 4, 1, 0);   // add $4 again
      tick();
      set_id(1, 4, 4, 12, 1, 0);  // use $4 on both operands
      tick();
      set_id(0, 0, 0, 0, 0, 0);
      n_total++; if (fwd_a_sel !== 2'b01) $display("FAIL prio_a: got %b want 01", fwd_a_sel); else n_pass++;
      n_total++; if (fwd_b_sel !== 2'b01) $display("FAIL prio_b: got %b want 01", fwd_b_sel); else n_pass++;
   endtask

   task automatic test_load_use();
      drain();
      set_id(1, 1, 2, 5, 1, 1);   // lw $5
      tick();
      set_id(1, 5, 2, 13, 1, 0);  // add rs=$5
      n_total++; if (stall_id !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall_id); else n_pass++;
      tick();                     // ID held upstream, bubble into EX
      n_total++; if (stall_id !== 1'b0) $display("FAIL lu_stall_once: got %b want 0", stall_id); else n_pass++;
      n_total++; if (fwd_a_sel !== 2'b00) $display("FAIL lu_bubble_a: got %b want 00", fwd_a_sel); else n_pass++;
      tick();
      set_id(0, 0, 0, 0, 0, 0);
      n_total++; if (fwd_a_sel !== 2'b10) $display("FAIL lu_wb_fwd_a: got %b want 10", fwd_a_sel); else n_pass++;
      n_total++; if (stall_id !== 1'b0) $display("FAIL lu_after_stall: got %b want 0", stall_id); else n_pass++;
   endtask

   task automatic test_zero_reg();
      drain();
      set_id(1, 1, 2, 0, 1, 0);   // add $0
      tick();
      set_id(1, 0, 0, 14, 1, 0);  // use $0
      tick();
      set_id(0, 0, 0, 0, 0, 0);
      n_total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) $display("FAIL zero_sel: got %b want 0000", {fwd_a_sel, fwd_b_sel}); else n_pass++;
      drain();
      set_id(1, 1, 2, 0, 1, 1);   // lw $0
      tick();
      set_id(1, 0, 0, 14, 1, 0);
      n_total++; if (stall_id !== 1'b0) $display("FAIL zero_nostall: got %b want 0", stall_id); else n_pass++;
   endtask

   task automatic test_flush();
      drain();
      set_id(1, 1, 2, 6, 1, 1);   // lw $6
      tick();
      set_id(1, 6, 9, 8, 1, 0);   // dependent, writes $8, killed by flush
      flush_ex = 1;
      #1;
      n_total++; if (stall_id !== 1'b0) $display("FAIL flush_nostall: got %b want 0", stall_id); else n_pass++;
      tick();
      flush_ex = 0;
      set_id(0, 0, 0, 0, 0, 0);
      tick();
      n_total++; if ({wb_regwrite, wb_dst} !== {1'b1, 5'd6}) $display("FAIL flush_lw_wb: got %b/%0d want 1/6", wb_regwrite, wb_dst); else n_pass++;
      tick();
      n_total++; if (wb_regwrite !== 1'b0) $display("FAIL flush_bubble_wb: got %b want 0", wb_regwrite); else n_pass++;
   endtask

   task automatic test_wb_tag();
      drain();
      set_id(1, 1, 0, 7, 1, 0);   // addi $7
      tick();
      set_id(0, 0, 0, 0, 0, 0);
      n_total++; if (wb_regwrite !== 1'b0) $display("FAIL tag_e1: got %b want 0", wb_regwrite); else n_pass++;
      tick();
      n_total++; if (wb_regwrite !== 1'b0) $display("FAIL tag_e2: got %b want 0", wb_regwrite); else n_pass++;
      tick();
      n_total++; if (wb_regwrite !== 1'b1) $display("FAIL tag_e3_we: got %b want 1", wb_regwrite); else n_pass++;
      n_total++; if (wb_dst !== 5'd7) $display("FAIL tag_e3_dst: got %0d want 7", wb_dst); else n_pass++;
      tick();
      n_total++; if (wb_regwrite !== 1'b0) $display("FAIL tag_e4: got %b want 0", wb_regwrite); else n_pass++;
   endtask

   task automatic test_reset_midstream();
      drain();
      set_id(1, 1, 2, 10, 1, 0);
      tick();
      set_id(1, 10, 2, 11, 1, 0);
      tick();
      set_id(1, 11, 10, 12, 1, 1);
      tick();
      n_total++; if ({wb_regwrite, wb_dst} !== {1'b1, 5'd10}) $display("FAIL mid_pre_wb: got %b/%0d want 1/10", wb_regwrite, wb_dst); else n_pass++;
      n_total++; if (fwd_a_sel !== 2'b01) $display("FAIL mid_pre_fwd_a: got %b want 01", fwd_a_sel); else n_pass++;
      set_id(1, 12, 0, 13, 1, 0); // would stall on the load in EX
      #1;
      rst = 1;
      #1;
      n_total++; if ({stall_id, fwd_a_sel, fwd_b_sel, wb_regwrite, wb_dst} !== 11'd0)
         $display("FAIL mid_reset_outputs: got %b want 0", {stall_id, fwd_a_sel, fwd_b_sel, wb_regwrite, wb_dst});
      else n_pass++;
      set_id(0, 0, 0, 0, 0, 0);
      tick();
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++; if (wb_regwrite !== 1'b0) $display("FAIL mid_post_wb%0d: got %b want 0", i, wb_regwrite); else n_pass++;
      end
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rst = 1;
      flush_ex = 0;
      id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0; id_regwrite = 0; id_memread = 0;
      test_reset();
      test_mem_fwd();
      test_wb_fwd();
      test_priority();
      test_load_use();
      test_zero_reg();
      test_flush();
      test_wb_tag();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
